model_memory_stream: RTL and testbench

Banked, parametrised model memory with streaming load and burst-read engines. Replaces the bare dual-port model store with a self-sequencing unit: the host loader pushes model words through a valid/ready write stream with auto-incrementing addresses, and the MLP datapath pulls bursts through a backpressured valid/ready read stream. Storage is split into NUM_BANKS block RAMs selected by upper address bits; the load and read engines run concurrently.

---
 rtl/model_memory_stream.sv | 226 ++++++++++++++++++++++
 tb/tb_model_memory_stream.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/model_memory_stream.sv
// -----------------------------------------------------------------------------
// model_memory_stream
//   Banked model memory with a streaming load engine (valid/ready write stream,
//   auto-incrementing address) and a burst-read engine (backpressured
//   valid/ready read stream). Both engines run concurrently.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ld_start/base/len   start a load burst (sampled while the load engine idles)
//   ld_valid/data/ready write stream; ld_busy, ld_done status
//   rd_start/base/len   start a read burst (sampled while the read engine idles)
//   rd_valid/data/ready read stream; rd_busy, rd_done status
// -----------------------------------------------------------------------------
module model_memory_stream #(
  parameter  int DATA_WIDTH      = 18,
  parameter  int BANK_ADDR_WIDTH = 10,
  parameter  int BANK_SEL_WIDTH  = 1,
  localparam int AW              = BANK_ADDR_WIDTH + BANK_SEL_WIDTH,
  localparam int LEN_WIDTH       = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_start,
  input  logic [AW-1:0]         ld_base,
  input  logic [LEN_WIDTH-1:0]  ld_len,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  ld_busy,
  output logic                  ld_done,
  input  logic                  rd_start,
  input  logic [AW-1:0]         rd_base,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  output logic                  rd_busy,
  output logic                  rd_done
);

  localparam int NUM_BANKS  = 1 << BANK_SEL_WIDTH;
  localparam int BANK_DEPTH = 1 << BANK_ADDR_WIDTH;

  localparam logic       L_IDLE  = 1'b0;
  localparam logic       L_RUN   = 1'b1;
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_RUN   = 2'd1;
  localparam logic [1:0] R_DRAIN = 2'd2;

  // ---------------------------------------------------------------------------
  // Load engine
  // ---------------------------------------------------------------------------
  logic                 r_ld_state;
  logic [AW-1:0]        r_ld_addr;
  logic [LEN_WIDTH-1:0] r_ld_cnt;
  logic                 r_ld_done;
  logic                 w_ld_fire;

  assign w_ld_fire = (r_ld_state == L_RUN) && ld_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_state <= L_IDLE;
      r_ld_addr  <= '0;
      r_ld_cnt   <= '0;
      r_ld_done  <= 1'b0;
    end else begin
      r_ld_done <= 1'b0;
      case (r_ld_state)
        L_IDLE: begin
          if (ld_start) begin
            if (ld_len != '0) begin
              r_ld_addr  <= ld_base;
              r_ld_cnt   <= ld_len;
              r_ld_state <= L_RUN;
            end else begin
              r_ld_done <= 1'b1;
            end
          end
        end
        default: begin
          if (w_ld_fire) begin
            r_ld_addr <= r_ld_addr + AW'(1);
            r_ld_cnt  <= r_ld_cnt - LEN_WIDTH'(1);
            if (r_ld_cnt == LEN_WIDTH'(1)) begin
              r_ld_state <= L_IDLE;
              r_ld_done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign ld_ready = (r_ld_state == L_RUN);
  assign ld_busy  = (r_ld_state == L_RUN);
  assign ld_done  = r_ld_done;

  // ---------------------------------------------------------------------------
  // Read issue control
  // ---------------------------------------------------------------------------
  logic [1:0]            r_rd_state;
  logic [AW-1:0]         r_rd_addr;
  logic [LEN_WIDTH-1:0]  r_rd_cnt;
  logic                  r_rd_done;
  logic                  r_bram_vld;
  logic [BANK_SEL_WIDTH-1:0] r_bram_bank;
  logic [DATA_WIDTH-1:0] r_fifo [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_fifo_cnt;

  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_credit;
  logic                  w_rd_go;
  logic                  w_rd_issue;
  logic [AW-1:0]         w_rd_addr;
  logic [BANK_SEL_WIDTH-1:0]  w_rd_bank;
  logic [BANK_ADDR_WIDTH-1:0] w_rd_off;
  logic [DATA_WIDTH-1:0] w_bank_q [NUM_BANKS];

  assign w_pop = (r_fifo_cnt != 2'd0) && rd_ready;
  // Words already buffered plus the one in the BRAM pipe, minus the one leaving
  // now; a new issue is allowed only if that leaves room in the 2-entry buffer.
  assign w_occ    = {1'b0, r_fifo_cnt} + {2'b00, r_bram_vld} - {2'b00, w_pop};
  assign w_credit = (w_occ < 3'd2);

  // The first read is issued in the start cycle itself (the buffer is always
  // empty when idle), which gives rd_valid two cycles after rd_start.
  assign w_rd_go    = (r_rd_state == R_IDLE) && rd_start && (rd_len != '0);
  assign w_rd_issue = w_credit && (w_rd_go || (r_rd_state == R_RUN));
  assign w_rd_addr  = (r_rd_state == R_IDLE) ? rd_base : r_rd_addr;
  assign w_rd_bank  = w_rd_addr[AW-1:BANK_ADDR_WIDTH];
  assign w_rd_off   = w_rd_addr[BANK_ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state <= R_IDLE;
      r_rd_addr  <= '0;
      r_rd_cnt   <= '0;
      r_rd_done  <= 1'b0;
    end else begin
      r_rd_done <= 1'b0;
      case (r_rd_state)
        R_IDLE: begin
          if (rd_start) begin
            if (rd_len != '0) begin
              r_rd_addr  <= rd_base + AW'(1);
              r_rd_cnt   <= rd_len - LEN_WIDTH'(1);
              r_rd_state <= (rd_len == LEN_WIDTH'(1)) ? R_DRAIN : R_RUN;
            end else begin
              r_rd_done <= 1'b1;
            end
          end
        end
        R_RUN: begin
          if (w_rd_issue) begin
            r_rd_addr <= r_rd_addr + AW'(1);
            r_rd_cnt  <= r_rd_cnt - LEN_WIDTH'(1);
            if (r_rd_cnt == LEN_WIDTH'(1)) r_rd_state <= R_DRAIN;
          end
        end
        default: begin
          // Leave once nothing is in flight and the last buffered word goes now.
          if (!r_bram_vld && ((r_fifo_cnt == 2'd0) ||
                              ((r_fifo_cnt == 2'd1) && w_pop))) begin
            r_rd_state <= R_IDLE;
            r_rd_done  <= 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory banks: simple dual-port, registered read, read-first
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] r_q;

    // NOTE: the storage array has no reset so it maps onto block RAM; model
    // contents survive a reset by design.
    always_ff @(posedge clk) begin
      if (w_rd_issue && (w_rd_bank == BANK_SEL_WIDTH'(b)))
        r_q <= r_mem[w_rd_off];
      if (w_ld_fire && (r_ld_addr[AW-1:BANK_ADDR_WIDTH] == BANK_SEL_WIDTH'(b)))
        r_mem[r_ld_addr[BANK_ADDR_WIDTH-1:0]] <= ld_data;
    end

    assign w_bank_q[b] = r_q;
  end

  // ---------------------------------------------------------------------------
  // BRAM pipe tracking and 2-entry output buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bram_vld  <= 1'b0;
      r_bram_bank <= '0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_fifo_cnt  <= 2'd0;
    end else begin
      r_bram_vld  <= w_rd_issue;
      r_bram_bank <= w_rd_bank;
      if (r_bram_vld) begin
        r_fifo[r_wr_ptr] <= w_bank_q[r_bram_bank];
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_fifo_cnt <= r_fifo_cnt + {1'b0, r_bram_vld} - {1'b0, w_pop};
    end
  end

  assign rd_valid = (r_fifo_cnt != 2'd0);
  assign rd_data  = r_fifo[r_rd_ptr];
  assign rd_busy  = (r_rd_state != R_IDLE);
  assign rd_done  = r_rd_done;

endmodule

// File: tb/tb_model_memory_stream.sv
// -----------------------------------------------------------------------------
// tb_model_memory_stream
//   Self-checking bench: a flat array mirrors memory contents; expected read
//   data is simply ref_mem[(base + i) mod 2^AW] for each beat of a burst.
// -----------------------------------------------------------------------------
module tb_model_memory_stream;

  localparam int DW    = 18;
  localparam int AW    = 11;
  localparam int LW    = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_start, ld_valid, ld_ready, ld_busy, ld_done;
  logic [AW-1:0] ld_base;
  logic [LW-1:0] ld_len;
  logic [DW-1:0] ld_data;
  logic          rd_start, rd_valid, rd_ready, rd_busy, rd_done;
  logic [AW-1:0] rd_base;
  logic [LW-1:0] rd_len;
  logic [DW-1:0] rd_data;

  logic [DW-1:0] ref_mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  model_memory_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_len   (ld_len),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .rd_start (rd_start),
    .rd_base  (rd_base),
    .rd_len   (rd_len),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .rd_busy  (rd_busy),
    .rd_done  (rd_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit ready_pat(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 3) == 0;   // 1,0,0,1,0,0,...
    return 1'($urandom_range(0, 1));
  endfunction

  // Load burst; stimulus applied and outputs observed at the falling edge.
  task automatic do_load(input int base, input int len, input bit rand_valid,
                         input bit seq_data, input int first_val);
    int beats = 0;
    int ready_cycles = 0;
    int budget = 0;
    bit v;
    @(negedge clk);
    ld_start = 1'b1;
    ld_base  = AW'(base);
    ld_len   = LW'(len);
    ld_valid = (len == 0);            // a stray valid must not write anything
    ld_data  = '1;
    @(negedge clk);
    ld_start = 1'b0;
    if (len == 0) begin
      check("ld_zero_done", int'(ld_done), 1);
      check("ld_zero_ready", int'(ld_ready), 0);
      check("ld_zero_busy", int'(ld_busy), 0);
      ld_valid = 1'b0;
      @(negedge clk);
      check("ld_zero_done_width", int'(ld_done), 0);
      return;
    end
    check("ld_ready_first", int'(ld_ready), 1);
    while (beats < len && budget < 20000) begin
      v = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (ld_ready) ready_cycles++;
      ld_valid = v;
      ld_data  = seq_data ? DW'(first_val + beats) : DW'($urandom);
      if (v && ld_ready) begin
        ref_mem[(base + beats) % DEPTH] = ld_data;
        beats++;
      end
      @(negedge clk);
      budget++;
    end
    ld_valid = 1'b0;
    check("ld_beats", beats, len);
    if (!rand_valid) check("ld_ready_cycles", ready_cycles, len);
    check("ld_done", int'(ld_done), 1);
    check("ld_busy_end", int'(ld_busy), 0);
    check("ld_ready_end", int'(ld_ready), 0);
    @(negedge clk);
    check("ld_done_width", int'(ld_done), 0);
  endtask

  // Read burst. mode: 0 ready high, 1 ready 1,0,0 pattern, 2 random ready.
  // restart pulses a second rd_start mid-burst; abort_after>0 resets the DUT
  // once that many beats have been consumed.
  task automatic do_read(input int base, input int len, input int mode,
                         input bit restart, input int abort_after);
    int cyc = 0;
    int got = 0;
    int first = -1;
    int last = 0;
    bit stall_prev = 1'b0;
    bit rdy;
    logic [DW-1:0] prev_data = '0;
    @(negedge clk);
    rd_start = 1'b1;
    rd_base  = AW'(base);
    rd_len   = LW'(len);
    rd_ready = ready_pat(mode, 0);
    if (len == 0) begin
      @(negedge clk);
      rd_start = 1'b0;
      check("rd_zero_done", int'(rd_done), 1);
      check("rd_zero_valid", int'(rd_valid), 0);
      check("rd_zero_busy", int'(rd_busy), 0);
      @(negedge clk);
      check("rd_zero_done_width", int'(rd_done), 0);
      return;
    end
    while (got < len && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      rd_start = restart && (cyc == 3);
      if (restart && cyc == 3) begin
        rd_base = AW'(base + 100);
        rd_len  = LW'(len + 5);
      end
      if (stall_prev) begin
        check("rd_hold_valid", int'(rd_valid), 1);
        check("rd_hold_data", int'(rd_data), int'(prev_data));
      end
      if (rd_done) check("rd_done_early", int'(rd_done), 0);
      if (rd_valid && first < 0) begin
        first = cyc;
        check("rd_latency", cyc, 2);
      end
      rdy = ready_pat(mode, cyc);
      rd_ready = rdy;
      if (rd_valid && rdy) begin
        check("rd_data", int'(rd_data), int'(ref_mem[(base + got) % DEPTH]));
        got++;
        last = cyc;
        if (abort_after > 0 && got == abort_after) begin
          @(posedge clk);
          #2;
          rst_n = 1'b0;
          #1;
          check("rst_rd_valid", int'(rd_valid), 0);
          check("rst_rd_busy", int'(rd_busy), 0);
          check("rst_rd_done", int'(rd_done), 0);
          rd_ready = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
      end
      stall_prev = rd_valid && !rdy;
      prev_data  = rd_data;
    end
    rd_start = 1'b0;
    check("rd_beats", got, len);
    if (mode == 0) check("rd_no_bubble", last - first + 1, len);
    @(negedge clk);
    check("rd_done", int'(rd_done), 1);
    check("rd_busy_end", int'(rd_busy), 0);
    check("rd_valid_end", int'(rd_valid), 0);
    @(negedge clk);
    check("rd_done_width", int'(rd_done), 0);
    check("rd_valid_after", int'(rd_valid), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_base = '0; ld_len = '0; ld_data = '0;
    rd_start = 1'b0; rd_ready = 1'b0; rd_base = '0; rd_len = '0;
    repeat (3) @(negedge clk);
    check("rst_ld_ready", int'(ld_ready), 0);
    check("rst_ld_busy", int'(ld_busy), 0);
    check("rst_ld_done", int'(ld_done), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_rd_busy", int'(rd_busy), 0);
    check("rst_rd_done", int'(rd_done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic load and read-back.
    do_load(0, 8, 1'b0, 1'b1, 'h100);
    do_read(0, 8, 0, 1'b0, 0);

    // Bank crossing and address wrap.
    do_load(DEPTH - 2, 4, 1'b0, 1'b1, 'h200);
    do_read(DEPTH - 2, 4, 0, 1'b0, 0);

    // Backpressure.
    do_read(0, 6, 1, 1'b0, 0);

    // Collision: write and read-issue of the same address in one cycle.
    do_load(5, 1, 1'b0, 1'b1, 'h0AA);
    @(negedge clk);
    ld_start = 1'b1; ld_base = AW'(5); ld_len = LW'(1); ld_valid = 1'b1;
    ld_data  = DW'('h155);
    @(negedge clk);
    ld_start = 1'b0;
    check("col_ld_ready", int'(ld_ready), 1);
    rd_start = 1'b1; rd_base = AW'(5); rd_len = LW'(1); rd_ready = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0; rd_start = 1'b0;
    check("col_ld_done", int'(ld_done), 1);
    @(negedge clk);
    check("col_rd_valid", int'(rd_valid), 1);
    check("col_rd_old", int'(rd_data), 'h0AA);
    @(negedge clk);
    check("col_rd_done", int'(rd_done), 1);
    ref_mem[5] = DW'('h155);
    do_read(5, 1, 0, 1'b0, 0);

    // Zero-length bursts and an ignored start during an active read.
    do_load(0, 0, 1'b0, 1'b0, 0);
    do_read(0, 8, 0, 1'b0, 0);
    do_read(0, 0, 0, 1'b0, 0);
    do_read(0, 8, 0, 1'b1, 0);

    // Full-memory burst with random valid/data, read back under random ready.
    do_load(0, DEPTH, 1'b1, 1'b0, 0);
    do_read(0, DEPTH, 2, 1'b0, 0);

    // Random bursts.
    for (int i = 0; i < 12; i++) begin
      int b;
      int l;
      b = int'($urandom_range(0, DEPTH - 1));
      l = int'($urandom_range(1, 40));
      do_load(b, l, 1'b1, 1'b0, 0);
      do_read(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)),
              int'($urandom_range(0, 2)), 1'b0, 0);
      do_read(b, l, 2, 1'b0, 0);
    end

    // Reset in the middle of a read burst, then a clean read.
    do_read(100, 8, 0, 1'b0, 3);
    do_read(100, 8, 0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
